// File: rtl/mod_check_pkg.sv
// Shared types, default parameters and the residue step for the modulo-check scheduler.
package mod_check_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV   = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One MSB-first step: r' = 2r + b, folded back into [0, div-1] with a single subtraction.
   function automatic int unsigned residue_step(input int unsigned r, input logic b,
                                                input int unsigned div);
      int unsigned t;
      t = (r << 1) + {31'd0, b};
      if (t >= div) begin
         return t - div;
      end else begin
         return t;
      end
   endfunction

endpackage

// File: rtl/mod_residue_serial.sv
// Bit-serial modulo-DIV residue engine: one input bit per step, single RW-bit register.
module mod_residue_serial
   import mod_check_pkg::*;
#(
   parameter  int DIV = DEF_DIV,
   localparam int RW  = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   input  logic          bit_in,
   output logic [RW-1:0] residue
);

   logic [RW-1:0] residue_r;

   // Residue register: clear wins over step so a new word always starts from 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         residue_r <= '0;
      end else if (clear) begin
         residue_r <= '0;
      end else if (step) begin
         residue_r <= RW'(residue_step({{(32-RW){1'b0}}, residue_r}, bit_in, DIV));
      end else begin
         residue_r <= residue_r;
      end
   end

   assign residue = residue_r;

endmodule

// File: rtl/mod_check_scheduler.sv
// Round-robin scheduler sharing one serial modulo-DIV engine among NREQ requesters.
// Optional port res_residue is enabled by defining MODCHK_RESIDUE_OUT_EN.
module mod_check_scheduler
   import mod_check_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV   = DEF_DIV
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic                     res_div,
`ifdef MODCHK_RESIDUE_OUT_EN
   output logic [$clog2(DIV)-1:0]   res_residue,
`endif
   output logic                     busy
);

   localparam int IW = $clog2(NREQ);
   localparam int RW = $clog2(DIV);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_r;
   state_t           state_next_s;
   logic [IW-1:0]    ptr_r;
   logic [IW-1:0]    grant_idx_s;
   logic             grant_any_s;
   logic [WIDTH-1:0] sh_r;
   logic [CW-1:0]    cnt_r;
   logic [IW-1:0]    id_r;
   logic             div_r;
   logic             eng_clear_s;
   logic             eng_step_s;
   logic [RW-1:0]    eng_res_s;

   // Round-robin search: descending scan so the lowest offset from the pointer wins.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr_r) + k) % NREQ;
         grant_any_s = req_valid[IW'(idx)] ? 1'b1 : grant_any_s;
         grant_idx_s = req_valid[IW'(idx)] ? IW'(idx) : grant_idx_s;
      end
   end

   // Grant strobe is combinational in IDLE and suppressed while reset is held.
   always_comb begin
      req_ready = '0;
      if ((state_r == IDLE) && grant_any_s && !reset) begin
         req_ready[grant_idx_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // FSM next state and engine controls.
   always_comb begin
      state_next_s = state_r;
      eng_clear_s  = 1'b0;
      eng_step_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_any_s) begin
               state_next_s = SHIFT;
               eng_clear_s  = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            eng_step_s = 1'b1;
            if (cnt_r == '0) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Word capture, shifting, bit counter, pointer advance and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_r <= '0;
         sh_r  <= '0;
         cnt_r <= '0;
         id_r  <= '0;
         div_r <= 1'b0;
      end else if ((state_r == IDLE) && grant_any_s) begin
         ptr_r <= IW'((int'(grant_idx_s) + 1) % NREQ);
         sh_r  <= req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
         cnt_r <= CW'(WIDTH - 1);
         id_r  <= grant_idx_s;
      end else if (state_r == SHIFT) begin
         sh_r <= sh_r << 1;
         if (cnt_r == '0) begin
            // The engine register lands on the same edge; derive res_div from the same step.
            div_r <= (residue_step({{(32-RW){1'b0}}, eng_res_s}, sh_r[WIDTH-1], DIV) == 32'd0);
         end else begin
            cnt_r <= cnt_r - 1'b1;
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   mod_residue_serial #(.DIV(DIV)) u_engine (
      .clk     (clk),
      .reset   (reset),
      .clear   (eng_clear_s),
      .step    (eng_step_s),
      .bit_in  (sh_r[WIDTH-1]),
      .residue (eng_res_s)
   );

   assign res_valid = (state_r == DONE);
   assign busy      = (state_r != IDLE);
   assign res_id    = id_r;
   assign res_div   = div_r;
`ifdef MODCHK_RESIDUE_OUT_EN
   assign res_residue = eng_res_s;
`endif

endmodule

// File: tb/tb_mod_check_scheduler.sv
// Self-checking bench for mod_check_scheduler: random words against a round-robin/modulo model.
module tb_mod_check_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DIV   = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_id;
   logic        res_div;
   logic        busy;
   logic [2:0]  res_residue_w;

   logic [1:0]  b_req_valid;
   logic [7:0]  b_req_data;
   logic [1:0]  b_req_ready;
   logic        b_res_valid;
   logic        b_res_ready;
   logic [0:0]  b_res_id;
   logic        b_res_div;
   logic        b_busy;
   logic [1:0]  b_res_residue_w;

   int          errors = 0;
   int          checks = 0;
   int          exp_ptr = 0;
   logic [3:0]  rdy_seen;

   always #5 clk = ~clk;

   mod_check_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_div(res_div),
`ifdef MODCHK_RESIDUE_OUT_EN
      .res_residue(res_residue_w),
`endif
      .busy(busy)
   );

   mod_check_scheduler #(.NREQ(2), .WIDTH(4), .DIV(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_data(b_req_data),
      .req_ready(b_req_ready), .res_valid(b_res_valid), .res_ready(b_res_ready),
      .res_id(b_res_id), .res_div(b_res_div),
`ifdef MODCHK_RESIDUE_OUT_EN
      .res_residue(b_res_residue_w),
`endif
      .busy(b_busy)
   );

`ifndef MODCHK_RESIDUE_OUT_EN
   assign res_residue_w   = 3'd0;
   assign b_res_residue_w = 2'd0;
`endif

   // Reference arbiter: first valid index at or above the pointer, wrapping.
   function automatic int model_grant(input logic [3:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1; req_valid = 4'b0; res_ready = 1'b1;
      b_req_valid = 2'b0; b_res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      exp_ptr = 0;
   endtask

   // Offers v/d and waits for a grant; returns at grant cycle + 1.
   task automatic issue(input logic [3:0] v, input logic [31:0] d, input bit drop,
                        output int g, output int waited);
      req_valid = v; req_data = d;
      #1;
      waited = 0;
      while (req_ready == 4'b0 && waited < 50) begin
         @(posedge clk); #1; waited++;
      end
      rdy_seen = req_ready;
      g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      @(posedge clk); #1;
      if (drop) req_valid = 4'b0;
   endtask

   // Waits for res_valid counting cycles from the grant cycle; transfers if res_ready is high.
   task automatic collect(output int lat, output logic [1:0] id, output logic dv,
                          output logic [2:0] rr);
      lat = 1;
      while (!res_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      id = res_id; dv = res_div; rr = res_residue_w;
      if (res_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 4'hF; req_data = 32'hFFFF_FFFF; res_ready = 1'b1;
      b_req_valid = 2'b0; b_req_data = 8'd0; b_res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
      checks++; if (res_div !== 1'b0) begin errors++; $display("FAIL reset_res_div: got %0b expected 0", res_div); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
`ifdef MODCHK_RESIDUE_OUT_EN
      checks++; if (res_residue_w !== 3'd0) begin errors++; $display("FAIL reset_residue: got %0d expected 0", res_residue_w); end
`endif
      req_valid = 4'b0;
      do_reset();
   endtask

   task automatic test_single();
      int reqs[4]  = '{0, 2, 2, 2};
      int words[4] = '{25, 7, 0, 255};
      int g, w, lat, eg;
      logic [1:0] id; logic dv; logic [2:0] rr;
      do_reset();
      for (int t = 0; t < 4; t++) begin
         logic [3:0] v;
         v = 4'(1 << reqs[t]);
         eg = model_grant(v);
         issue(v, 32'(words[t]) << (reqs[t] * WIDTH), 1'b1, g, w);
         exp_ptr = (eg + 1) % NREQ;
         checks++; if (g !== eg) begin errors++; $display("FAIL single_grant[%0d]: got %0d expected %0d", t, g, eg); end
         checks++; if (rdy_seen !== 4'(1 << eg)) begin errors++; $display("FAIL single_onehot[%0d]: got %b expected %b", t, rdy_seen, 4'(1 << eg)); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy[%0d]: got %0b expected 1", t, busy); end
         collect(lat, id, dv, rr);
         checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL single_latency[%0d]: got %0d expected %0d", t, lat, WIDTH + 1); end
         checks++; if (id !== 2'(eg)) begin errors++; $display("FAIL single_id[%0d]: got %0d expected %0d", t, id, eg); end
         checks++; if (dv !== ((words[t] % DIV) == 0)) begin errors++; $display("FAIL single_div[%0d]: got %0b expected %0b", t, dv, (words[t] % DIV) == 0); end
`ifdef MODCHK_RESIDUE_OUT_EN
         checks++; if (rr !== 3'(words[t] % DIV)) begin errors++; $display("FAIL single_residue[%0d]: got %0d expected %0d", t, rr, words[t] % DIV); end
`endif
      end
   endtask

   task automatic test_round_robin();
      int g, w, lat, eg;
      logic [1:0] id; logic dv; logic [2:0] rr;
      logic [31:0] d;
      logic [3:0] v;
      do_reset();
      d = $urandom();
      for (int t = 0; t < 7; t++) begin
         v = (t < 5) ? 4'b1111 : 4'b0110;
         eg = model_grant(v);
         issue(v, d, 1'b0, g, w);
         exp_ptr = (eg + 1) % NREQ;
         checks++; if (g !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", t, g, eg); end
         if (t > 0 && t != 5) begin
            checks++; if (w !== 0) begin errors++; $display("FAIL rr_interval[%0d]: got %0d extra cycles expected 0", t, w); end
         end
         checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rr_no_grant_busy[%0d]: got %b expected 0000", t, req_ready); end
         collect(lat, id, dv, rr);
         checks++; if (dv !== ((d[eg*8 +: 8] % DIV) == 0)) begin errors++; $display("FAIL rr_div[%0d]: got %0b expected %0b", t, dv, (d[eg*8 +: 8] % DIV) == 0); end
      end
      req_valid = 4'b0;
   endtask

   task automatic test_backpressure();
      int g, w, lat, eg;
      logic [1:0] id; logic dv; logic [2:0] rr;
      logic [31:0] d;
      logic expdiv;
      d = $urandom();
      res_ready = 1'b0;
      eg = model_grant(4'b1111);
      issue(4'b1111, d, 1'b0, g, w);
      exp_ptr = (eg + 1) % NREQ;
      expdiv = (d[eg*8 +: 8] % DIV) == 0;
      collect(lat, id, dv, rr);
      checks++; if (lat !== WIDTH + 1) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, WIDTH + 1); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b expected 1", c, res_valid); end
         checks++; if (res_id !== 2'(eg)) begin errors++; $display("FAIL bp_id[%0d]: got %0d expected %0d", c, res_id, eg); end
         checks++; if (res_div !== expdiv) begin errors++; $display("FAIL bp_div[%0d]: got %0b expected %0b", c, res_div, expdiv); end
         checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %0b expected 1", c, busy); end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      eg = model_grant(4'b1111);
      checks++; if (req_ready !== 4'(1 << eg)) begin errors++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, 4'(1 << eg)); end
      issue(4'b1111, d, 1'b1, g, w);
      exp_ptr = (eg + 1) % NREQ;
      collect(lat, id, dv, rr);
      checks++; if (id !== 2'(eg)) begin errors++; $display("FAIL bp_after_id: got %0d expected %0d", id, eg); end
   endtask

   task automatic test_reset_midshift();
      int g, w, lat, eg;
      logic [1:0] id; logic dv; logic [2:0] rr;
      bit seen;
      res_ready = 1'b1;
      issue(4'b1100, 32'hA5A5_A5A5, 1'b0, g, w);
      repeat (3) begin @(posedge clk); #1; end
      req_valid = 4'b1010;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", res_valid); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL mid_id: got %0d expected 0", res_id); end
      checks++; if (res_div !== 1'b0) begin errors++; $display("FAIL mid_div: got %0b expected 0", res_div); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0000", req_ready); end
      req_valid = 4'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_ptr = 0;
      seen = 1'b0;
      repeat (WIDTH + 4) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_result: got %0b expected 0", seen); end
      eg = model_grant(4'b1010);
      issue(4'b1010, 32'h0000_1900, 1'b1, g, w);
      exp_ptr = (eg + 1) % NREQ;
      checks++; if (g !== 1) begin errors++; $display("FAIL mid_regrant: got %0d expected 1", g); end
      collect(lat, id, dv, rr);
      checks++; if (dv !== 1'b1) begin errors++; $display("FAIL mid_regrant_div: got %0b expected 1", dv); end
   endtask

   task automatic test_random();
      int g, w, lat, eg;
      logic [1:0] id; logic dv; logic [2:0] rr;
      logic [31:0] d;
      logic [3:0] v;
      res_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         v = 4'($urandom_range(1, 15));
         d = $urandom();
         eg = model_grant(v);
         issue(v, d, 1'b1, g, w);
         exp_ptr = (eg + 1) % NREQ;
         checks++; if (g !== eg) begin errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", t, g, eg); end
         collect(lat, id, dv, rr);
         checks++; if (id !== 2'(eg)) begin errors++; $display("FAIL rand_id[%0d]: got %0d expected %0d", t, id, eg); end
         checks++; if (dv !== ((d[eg*8 +: 8] % DIV) == 0)) begin errors++; $display("FAIL rand_div[%0d]: got %0b expected %0b", t, dv, (d[eg*8 +: 8] % DIV) == 0); end
`ifdef MODCHK_RESIDUE_OUT_EN
         checks++; if (rr !== 3'(d[eg*8 +: 8] % DIV)) begin errors++; $display("FAIL rand_residue[%0d]: got %0d expected %0d", t, rr, d[eg*8 +: 8] % DIV); end
`endif
      end
   endtask

   task automatic test_div3();
      int words[2] = '{9, 10};
      int n;
      b_res_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         b_req_valid = 2'b01; b_req_data = 8'(words[t]);
         #1;
         checks++; if (b_req_ready !== 2'b01) begin errors++; $display("FAIL d3_grant[%0d]: got %b expected 01", t, b_req_ready); end
         @(posedge clk); #1;
         b_req_valid = 2'b00;
         n = 1;
         while (!b_res_valid && n < 40) begin @(posedge clk); #1; n++; end
         checks++; if (n !== 5) begin errors++; $display("FAIL d3_latency[%0d]: got %0d expected 5", t, n); end
         checks++; if (b_res_div !== ((words[t] % 3) == 0)) begin errors++; $display("FAIL d3_div[%0d]: got %0b expected %0b", t, b_res_div, (words[t] % 3) == 0); end
`ifdef MODCHK_RESIDUE_OUT_EN
         checks++; if (b_res_residue_w !== 2'(words[t] % 3)) begin errors++; $display("FAIL d3_residue[%0d]: got %0d expected %0d", t, b_res_residue_w, words[t] % 3); end
`endif
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_midshift();
      test_random();
      test_div3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
